// File: rtl/uart_frame_packer_if.sv
// uart_frame_packer_if: control, measurement and UART-side signals of the frame packer.
// master: the packer itself. slave: the surrounding logic (controller, UART and sources).
interface uart_frame_packer_if #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 32
);
   logic [1:0]               mode;
   logic                     is_high;
   logic                     auto_en;
   logic                     start;
   logic [NUM_CH*DATA_W-1:0] data_in;
   logic                     tx_ready;
   logic [7:0]               tx_data;
   logic                     tx_valid;
   logic                     busy;
   logic                     frame_done;

   modport master (
      input  mode, is_high, auto_en, start, data_in, tx_ready,
      output tx_data, tx_valid, busy, frame_done
   );

   modport slave (
      output mode, is_high, auto_en, start, data_in, tx_ready,
      input  tx_data, tx_valid, busy, frame_done
   );
endinterface

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: snapshots up to NUM_CH measurement words and sends one frame
//   'P', status, payload (MSB byte first, ch0 first), [checksum], CR, LF
// to a UART transmitter, one tx_valid strobe per byte, strobes GAP_CYCLES clocks apart.
// Build option: define UART_FRAME_CHECKSUM_EN to insert an XOR checksum byte
// (status ^ all payload bytes) between the last payload byte and CR.
// Note: the shortest byte spacing the SEND/GAP loop can produce is 2 clocks.
module uart_frame_packer #(
   parameter int NUM_CH     = 3,
   parameter int DATA_W     = 32,
   parameter int GAP_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   uart_frame_packer_if.master bus
);
   localparam int BPC    = DATA_W / 8;
   localparam int NUM_PB = NUM_CH * BPC;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam int CK_BYTES = 1;
`else
   localparam int CK_BYTES = 0;
`endif
   localparam int MAX_LEN = 4 + NUM_PB + CK_BYTES;
   localparam int IDX_W   = $clog2(MAX_LEN);
   localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [IDX_W-1:0] MULTI_LAST  = IDX_W'(MAX_LEN - 1);
   localparam logic [IDX_W-1:0] SINGLE_LAST = IDX_W'(4 + BPC + CK_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_SEND = 2'b10,
      ST_GAP  = 2'b11
   } state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [IDX_W-1:0]         last_q, last_d;
   logic [GAP_W-1:0]         gap_q, gap_d;
   logic [7:0]               status_q, status_d;
   logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
   logic [7:0]               tx_data_q, tx_data_d;
   logic                     tx_valid_q, tx_valid_d;
   logic                     busy_q, busy_d;
   logic                     frame_done_q, frame_done_d;

   logic [7:0]               payload_s [NUM_PB];
   logic [7:0]               cur_byte_s;

`ifdef UART_FRAME_CHECKSUM_EN
   // XOR of the status byte and every payload byte that belongs to this frame
   function automatic logic [7:0] frame_xor(input logic [7:0] st,
                                            input logic [NUM_CH*DATA_W-1:0] snap,
                                            input logic multi);
      logic [7:0] acc;
      acc = st;
      for (int k = 0; k < NUM_PB; k++) begin
         if (multi || (k < BPC)) begin
            acc = acc ^ snap[k*8 +: 8];
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction
`endif

   // Payload bytes in transmit order: channel 0 first, most significant byte first
   always_comb begin
      for (int k = 0; k < NUM_PB; k++) begin
         payload_s[k] = snap_q[(k / BPC) * DATA_W + (BPC - 1 - (k % BPC)) * 8 +: 8];
      end
   end

   // Byte addressed by the frame index; the tail bytes are located relative to the last index
   always_comb begin
      cur_byte_s = 8'h0A;
      if (idx_q == '0) begin
         cur_byte_s = 8'h50;
      end else if (idx_q == IDX_W'(1)) begin
         cur_byte_s = status_q;
      end else if (idx_q == last_q) begin
         cur_byte_s = 8'h0A;
      end else if (idx_q == last_q - IDX_W'(1)) begin
         cur_byte_s = 8'h0D;
`ifdef UART_FRAME_CHECKSUM_EN
      end else if (idx_q == last_q - IDX_W'(2)) begin
         cur_byte_s = frame_xor(status_q, snap_q, last_q == MULTI_LAST);
`endif
      end else begin
         cur_byte_s = 8'h00;
         for (int k = 0; k < NUM_PB; k++) begin
            if (idx_q == IDX_W'(k + 2)) begin
               cur_byte_s = payload_s[k];
            end else begin
               cur_byte_s = cur_byte_s;
            end
         end
      end
   end

   // Frame sequencing: trigger, snapshot, paced byte issue with back-pressure
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_d       = last_q;
      gap_d        = gap_q;
      status_d     = status_q;
      snap_d       = snap_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = 1'b0;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((bus.start || bus.auto_en) && (bus.mode != 2'b00)) begin
               state_d = ST_LOAD;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            snap_d  = bus.data_in;
            idx_d   = '0;
            state_d = ST_SEND;
            if (bus.mode == 2'b11) begin
               status_d = bus.is_high ? 8'h33 : 8'h34;
               last_d   = MULTI_LAST;
            end else begin
               status_d = bus.is_high ? 8'h31 : 8'h32;
               last_d   = SINGLE_LAST;
            end
         end
         ST_SEND: begin
            if (bus.tx_ready && (gap_q == '0)) begin
               tx_data_d    = cur_byte_s;
               tx_valid_d   = 1'b1;
               frame_done_d = (idx_q == last_q);
               gap_d        = GAP_LOAD;
               state_d      = ST_GAP;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_GAP: begin
            // SEND plus this wait span exactly GAP_CYCLES clocks between strobes
            if (gap_q <= GAP_W'(1)) begin
               gap_d = '0;
               if (idx_q == last_q) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_SEND;
               end
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         last_q       <= '0;
         gap_q        <= '0;
         status_q     <= 8'h00;
         snap_q       <= '0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         gap_q        <= gap_d;
         status_q     <= status_d;
         snap_q       <= snap_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.tx_data    = tx_data_q;
   assign bus.tx_valid   = tx_valid_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: directed and randomized frames checked against a byte-list model.
module tb_uart_frame_packer;
   localparam int NUM_CH = 3;
   localparam int DATA_W = 32;
   localparam int GAP    = 4;

   typedef logic [7:0] byte_q_t [$];

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   int         stray_done = 0;
   bit         bp_mode = 1'b0;
   logic [7:0] cap_b [$];
   int         cap_c [$];
   logic       cap_d [$];

   uart_frame_packer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   uart_frame_packer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // capture every strobed byte with its clock number and frame_done flag
   always @(negedge clk) begin
      if (!rst && bus.tx_valid) begin
         cap_b.push_back(bus.tx_data);
         cap_c.push_back(cyc);
         cap_d.push_back(bus.frame_done);
      end else if (!rst && bus.frame_done) begin
         stray_done++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      cap_b.delete();
      cap_c.delete();
      cap_d.delete();
   endtask

   // frame content from the protocol rules
   function automatic byte_q_t model_frame(input bit multi, input bit hi,
                                           input logic [NUM_CH*DATA_W-1:0] d);
      byte_q_t    q;
      logic [7:0] st, x, b;
      logic [DATA_W-1:0] w;
      int         nch;
      nch = multi ? NUM_CH : 1;
      st  = multi ? (hi ? 8'h33 : 8'h34) : (hi ? 8'h31 : 8'h32);
      x   = st;
      q.push_back(8'h50);
      q.push_back(st);
      for (int ch = 0; ch < nch; ch++) begin
         w = d[ch*DATA_W +: DATA_W];
         for (int i = DATA_W/8 - 1; i >= 0; i--) begin
            b = w[i*8 +: 8];
            q.push_back(b);
            x = x ^ b;
         end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      q.push_back(x);
`endif
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   task automatic pulse_start(output int s);
      bus.start = 1'b1;
      tick(1);
      s = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_bytes(input string tag, input int n);
      int k;
      k = 0;
      while (cap_b.size() < n && k < 3000) begin
         tick(1);
         k++;
      end
      chk({tag, "_wait"}, cap_b.size() >= n, 1'b1);
   endtask

   task automatic wait_done(input string tag, input int n);
      int k;
      k = 0;
      while ((cap_b.size() < n || bus.busy) && k < 6000) begin
         if (bp_mode) bus.tx_ready = 1'($urandom_range(0, 1));
         tick(1);
         k++;
      end
      chk({tag, "_timeout"}, k < 6000, 1'b1);
      bus.tx_ready = 1'b1;
      tick(6);
   endtask

   task automatic compare_frame(input string tag, input byte_q_t exp, input int off, input bit exact);
      int dt;
      for (int i = 0; i < exp.size(); i++) begin
         if (off + i < cap_b.size()) begin
            chk($sformatf("%s_b%0d", tag, i), cap_b[off+i], exp[i]);
            chk($sformatf("%s_done%0d", tag, i), cap_d[off+i], (i == exp.size() - 1));
            if (i > 0) begin
               dt = cap_c[off+i] - cap_c[off+i-1];
               if (exact) chk($sformatf("%s_gap%0d", tag, i), dt, GAP);
               else       chk($sformatf("%s_gapmin%0d", tag, i), dt >= GAP, 1'b1);
            end
         end else begin
            chk($sformatf("%s_missing%0d", tag, i), cap_b.size(), off + i + 1);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r, n;
      byte_q_t exp;
      logic [NUM_CH*DATA_W-1:0] d;
      logic [1:0] m;
      logic hi;

      rst = 1'b1;
      bus.mode = 2'b00; bus.is_high = 1'b0; bus.auto_en = 1'b0; bus.start = 1'b0;
      bus.data_in = '0; bus.tx_ready = 1'b1;
      tick(3);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.frame_done, 1'b0);
      rst = 1'b0;
      tick(2);

      // single channel, high range
      clear_cap();
      bus.mode = 2'b01; bus.is_high = 1'b1;
      bus.data_in = {32'h0, 32'h0, 32'h12345678};
      exp = model_frame(1'b0, 1'b1, bus.data_in);
      pulse_start(s);
      chk("t1_busy", bus.busy, 1'b1);
      wait_done("t1", exp.size());
      chk("t1_len", cap_b.size(), exp.size());
      compare_frame("t1", exp, 0, 1'b1);
      if (cap_c.size() > 0) chk("t1_latency", cap_c[0] - s, 2);
      chk("t1_busy_end", bus.busy, 1'b0);

      // all channels, low range, inputs changed right after the snapshot
      clear_cap();
      bus.mode = 2'b11; bus.is_high = 1'b0;
      bus.data_in = {32'hC1C2C3C4, 32'hB1B2B3B4, 32'hA1A2A3A4};
      exp = model_frame(1'b1, 1'b0, bus.data_in);
      pulse_start(s);
      tick(1);
      bus.data_in = {32'h11111111, 32'h22222222, 32'h33333333};
      bus.mode = 2'b01; bus.is_high = 1'b1;
      wait_done("t2", exp.size());
      chk("t2_len", cap_b.size(), exp.size());
      compare_frame("t2", exp, 0, 1'b1);
      // next frame picks up the new values
      clear_cap();
      exp = model_frame(1'b0, 1'b1, bus.data_in);
      pulse_start(s);
      wait_done("t2n", exp.size());
      chk("t2n_len", cap_b.size(), exp.size());
      compare_frame("t2n", exp, 0, 1'b1);

      // mode 00 ignores start
      clear_cap();
      bus.mode = 2'b00;
      pulse_start(s);
      tick(20);
      chk("t3_nobytes", cap_b.size(), 0);
      chk("t3_busy", bus.busy, 1'b0);

      // back-pressure before byte 3
      clear_cap();
      bus.mode = 2'b11; bus.is_high = 1'b1;
      bus.data_in = {32'h0BADF00D, 32'hDEADBEEF, 32'hCAFE1234};
      exp = model_frame(1'b1, 1'b1, bus.data_in);
      pulse_start(s);
      wait_bytes("t4", 3);
      bus.tx_ready = 1'b0;
      tick(20);
      chk("t4_stalled", cap_b.size(), 3);
      r = cyc;
      bus.tx_ready = 1'b1;
      wait_done("t4", exp.size());
      chk("t4_len", cap_b.size(), exp.size());
      compare_frame("t4", exp, 0, 1'b0);
      if (cap_c.size() > 4) begin
         chk("t4_resume", cap_c[3] - r, 1);
         chk("t4_after", cap_c[4] - cap_c[3], GAP);
      end

      // auto trigger, then mode 00 mid-frame
      clear_cap();
      bus.mode = 2'b10; bus.is_high = 1'b0;
      bus.data_in = {32'h0, 32'h0, 32'h5A0FF0A5};
      exp = model_frame(1'b0, 1'b0, bus.data_in);
      n = exp.size();
      bus.auto_en = 1'b1;
      wait_bytes("t5", 2*n + 2);
      bus.mode = 2'b00;
      wait_done("t5", 3*n);
      tick(20);
      chk("t5_len", cap_b.size(), 3*n);
      compare_frame("t5f0", exp, 0, 1'b1);
      compare_frame("t5f1", exp, n, 1'b1);
      compare_frame("t5f2", exp, 2*n, 1'b1);
      if (cap_c.size() > n) chk("t5_b2b", cap_c[n] - cap_c[n-1], GAP + 2);
      chk("t5_idle", bus.busy, 1'b0);
      bus.auto_en = 1'b0;

      // reset in the middle of a frame
      clear_cap();
      bus.mode = 2'b11; bus.is_high = 1'b0;
      bus.data_in = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
      exp = model_frame(1'b1, 1'b0, bus.data_in);
      pulse_start(s);
      wait_bytes("t6", 5);
      rst = 1'b1;
      #1;
      chk("t6_rst_data", bus.tx_data, 8'h00);
      chk("t6_rst_valid", bus.tx_valid, 1'b0);
      chk("t6_rst_busy", bus.busy, 1'b0);
      chk("t6_rst_done", bus.frame_done, 1'b0);
      tick(2);
      rst = 1'b0;
      clear_cap();
      tick(15);
      chk("t6_noresume", cap_b.size(), 0);
      pulse_start(s);
      wait_done("t6", exp.size());
      chk("t6_len", cap_b.size(), exp.size());
      compare_frame("t6", exp, 0, 1'b1);

      // randomized frames with scrambled inputs, dropped starts and optional back-pressure
      for (int t = 0; t < 8; t++) begin
         clear_cap();
         m  = 2'($urandom_range(1, 3));
         hi = 1'($urandom_range(0, 1));
         d  = {$urandom, $urandom, $urandom};
         bp_mode = 1'($urandom_range(0, 1));
         bus.mode = m; bus.is_high = hi; bus.data_in = d;
         exp = model_frame(m == 2'b11, hi, d);
         pulse_start(s);
         tick(1);
         bus.data_in = {$urandom, $urandom, $urandom};
         bus.mode = 2'($urandom_range(0, 3));
         bus.is_high = ~hi;
         bus.start = 1'b1;
         tick(1);
         bus.start = 1'b0;
         wait_done($sformatf("r%0d", t), exp.size());
         chk($sformatf("r%0d_len", t), cap_b.size(), exp.size());
         compare_frame($sformatf("r%0d", t), exp, 0, !bp_mode);
      end
      bp_mode = 1'b0;

      chk("stray_done", stray_done, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
